// File: rtl/lock_pkg.sv
// Shared state encoding and parameter defaults for the code lock engine.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_PROG    = 3'd1,
        ST_ENTRY   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_t;

    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_MAX_LEN        = 8;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/code_lock_engine_if.sv
// Request/status bundle between keypad front end (master) and lock engine (slave).
interface code_lock_engine_if import lock_pkg::*; #(
    parameter int DIGIT_W   = DEF_DIGIT_W,
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int MAX_FAILS = DEF_MAX_FAILS
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic [DIGIT_W-1:0]         digit_in;
    logic                       digit_valid;
    logic                       store_req;
    logic                       submit_req;
    logic                       clear_req;
    logic                       unlock;
    logic                       locked_out;
    logic                       bad_code;
    logic                       pw_set;
    logic [FAIL_W-1:0]          fail_count;
    logic [LEN_W-1:0]           entry_len;
    logic [MAX_LEN*DIGIT_W-1:0] disp_digits;

    modport master (
        output digit_in, digit_valid, store_req, submit_req, clear_req,
        input  unlock, locked_out, bad_code, pw_set, fail_count, entry_len, disp_digits
    );

    modport slave (
        input  digit_in, digit_valid, store_req, submit_req, clear_req,
        output unlock, locked_out, bad_code, pw_set, fail_count, entry_len, disp_digits
    );

endinterface

// File: rtl/lockout_timer.sv
// Lockout down-counter: loaded by start, done is high in the last counting cycle.
module lockout_timer import lock_pkg::*; #(
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic count,
    output logic done
);
    localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(LOCKOUT_CYCLES);
        end else if (count && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Cycle k of the lockout sees cnt = LOCKOUT_CYCLES-k+1, so the exit edge ends cycle LOCKOUT_CYCLES.
    assign done = count && (cnt == CNT_W'(1));

endmodule

// File: rtl/code_lock_engine.sv
// Digit-code lock: password programming, code entry/compare, fail counting and timed lockout.
module code_lock_engine import lock_pkg::*; #(
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int MAX_LEN        = DEF_MAX_LEN,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic               clk,
    input  logic               system_reset,
    code_lock_engine_if.slave  bus
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    lock_state_t        state, state_nxt;
    logic [DIGIT_W-1:0] ent_dig [MAX_LEN];
    logic [DIGIT_W-1:0] pw_dig  [MAX_LEN];
    logic [LEN_W-1:0]   ent_len, pw_len, cap_idx;
    logic [FAIL_W-1:0]  fail_count;
    logic               ovf, pw_set, bad_code;
    logic               clr_entry, cap_digit, commit_pw, set_bad;
    logic               fail_inc, fail_clr, timer_start, timer_done, code_match;
    logic [MAX_LEN*DIGIT_W-1:0] disp;

    lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
        .clk   (clk),
        .rst   (system_reset),
        .start (timer_start),
        .count (state == ST_LOCKOUT),
        .done  (timer_done)
    );

    always_comb begin
        code_match = pw_set && !ovf && (ent_len == pw_len);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < pw_len && ent_dig[i] != pw_dig[i]) code_match = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) state <= ST_LOCKED;
        else              state <= state_nxt;
    end

    // Requests are examined in priority order clear > submit > store > digit; the first one wins.
    always_comb begin
        state_nxt   = state;
        clr_entry   = 1'b0;
        cap_digit   = 1'b0;
        commit_pw   = 1'b0;
        set_bad     = 1'b0;
        fail_inc    = 1'b0;
        fail_clr    = 1'b0;
        timer_start = 1'b0;
        case (state)
            ST_LOCKED: begin
                if (!bus.clear_req && !bus.submit_req) begin
                    if (bus.store_req) begin
                        if (!pw_set) begin
                            state_nxt = ST_PROG;
                            clr_entry = 1'b1;
                        end
                    end else if (bus.digit_valid) begin
                        state_nxt = ST_ENTRY;
                        clr_entry = 1'b1;
                        cap_digit = 1'b1;
                    end
                end
            end
            ST_PROG, ST_ENTRY: begin
                if (bus.clear_req) begin
                    state_nxt = ST_LOCKED;
                    clr_entry = 1'b1;
                end else if (bus.submit_req) begin
                    if (state == ST_PROG) begin
                        commit_pw = (ent_len != '0);
                        state_nxt = ST_LOCKED;
                        clr_entry = 1'b1;
                    end else if (code_match) begin
                        state_nxt = ST_OPEN;
                        fail_clr  = 1'b1;
                    end else begin
                        set_bad  = 1'b1;
                        fail_inc = 1'b1;
                        if (fail_count == FAIL_W'(MAX_FAILS - 1)) begin
                            state_nxt   = ST_LOCKOUT;
                            timer_start = 1'b1;
                        end else begin
                            state_nxt = ST_LOCKED;
                            clr_entry = 1'b1;
                        end
                    end
                end else if (!bus.store_req && bus.digit_valid) begin
                    cap_digit = 1'b1;
                end
            end
            ST_OPEN: begin
                if (!bus.clear_req) begin
                    if (bus.submit_req) begin
                        state_nxt = ST_LOCKED;
                        clr_entry = 1'b1;
                    end else if (bus.store_req) begin
                        state_nxt = ST_PROG;
                        clr_entry = 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_nxt = ST_LOCKED;
                    clr_entry = 1'b1;
                    fail_clr  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_LOCKED;
                clr_entry = 1'b1;
            end
        endcase
    end

    // A digit captured in the same cycle as the clear lands at index 0.
    assign cap_idx = clr_entry ? '0 : ent_len;

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            ent_len    <= '0;
            pw_len     <= '0;
            ovf        <= 1'b0;
            pw_set     <= 1'b0;
            bad_code   <= 1'b0;
            fail_count <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                ent_dig[i] <= '0;
                pw_dig[i]  <= '0;
            end
        end else begin
            bad_code <= set_bad;
            if (fail_clr)      fail_count <= '0;
            else if (fail_inc) fail_count <= fail_count + 1'b1;
            if (commit_pw) begin
                pw_set <= 1'b1;
                pw_len <= ent_len;
                for (int i = 0; i < MAX_LEN; i++) pw_dig[i] <= ent_dig[i];
            end
            if (clr_entry) begin
                ent_len <= '0;
                ovf     <= 1'b0;
                for (int i = 0; i < MAX_LEN; i++) ent_dig[i] <= '0;
            end
            if (cap_digit) begin
                if (cap_idx == LEN_W'(MAX_LEN)) begin
                    ovf <= 1'b1;
                end else begin
                    ent_len <= cap_idx + 1'b1;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (cap_idx == LEN_W'(i)) ent_dig[i] <= bus.digit_in;
                    end
                end
            end
        end
    end

    always_comb begin
        disp = '0;
        for (int i = 0; i < MAX_LEN; i++) disp[i*DIGIT_W +: DIGIT_W] = ent_dig[i];
    end

    assign bus.unlock      = (state == ST_OPEN);
    assign bus.locked_out  = (state == ST_LOCKOUT);
    assign bus.bad_code    = bad_code;
    assign bus.pw_set      = pw_set;
    assign bus.fail_count  = fail_count;
    assign bus.entry_len   = ent_len;
    assign bus.disp_digits = disp;

endmodule

// File: tb/tb_code_lock_engine.sv
// Bench for code_lock_engine: directed scenarios plus random pulses against a queue-based model.
module tb_code_lock_engine;
    localparam int DW = 4;
    localparam int ML = 4;
    localparam int MF = 3;
    localparam int LC = 10;

    localparam int M_LOCKED  = 0;
    localparam int M_PROG    = 1;
    localparam int M_ENTRY   = 2;
    localparam int M_OPEN    = 3;
    localparam int M_LOCKOUT = 4;

    logic clk = 1'b0;
    logic system_reset;
    int   total = 0;
    int   bad   = 0;

    code_lock_engine_if #(.DIGIT_W(DW), .MAX_LEN(ML), .MAX_FAILS(MF)) bus ();

    code_lock_engine #(.DIGIT_W(DW), .MAX_LEN(ML), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
        .clk          (clk),
        .system_reset (system_reset),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Reference model: entered/stored codes as queues, mode per the lock's rules.
    int mode;
    int ent[$];
    int pw[$];
    bit ovf_m, pw_set_m, bad_m;
    int fails, left;

    function automatic void m_reset();
        mode = M_LOCKED; ent.delete(); pw.delete();
        ovf_m = 0; pw_set_m = 0; bad_m = 0; fails = 0; left = 0;
    endfunction

    function automatic void m_clear();
        ent.delete(); ovf_m = 0;
    endfunction

    function automatic bit m_match();
        if (!pw_set_m || ovf_m || ent.size() != pw.size()) return 0;
        foreach (pw[i]) if (ent[i] != pw[i]) return 0;
        return 1;
    endfunction

    function automatic void m_push(int d);
        if (ent.size() < ML) ent.push_back(d);
        else ovf_m = 1;
    endfunction

    function automatic void model_edge(bit c, bit s, bit st, bit d, int dig);
        bad_m = 0;
        if (mode == M_LOCKOUT) begin
            left--;
            if (left == 0) begin mode = M_LOCKED; fails = 0; m_clear(); end
        end else if (c) begin
            if (mode == M_PROG || mode == M_ENTRY) begin mode = M_LOCKED; m_clear(); end
        end else if (s) begin
            if (mode == M_PROG) begin
                if (ent.size() >= 1) begin pw = ent; pw_set_m = 1; end
                mode = M_LOCKED; m_clear();
            end else if (mode == M_ENTRY) begin
                if (m_match()) begin mode = M_OPEN; fails = 0; end
                else begin
                    bad_m = 1; fails++;
                    if (fails == MF) begin mode = M_LOCKOUT; left = LC; end
                    else begin mode = M_LOCKED; m_clear(); end
                end
            end else if (mode == M_OPEN) begin
                mode = M_LOCKED; m_clear();
            end
        end else if (st) begin
            if ((mode == M_LOCKED && !pw_set_m) || mode == M_OPEN) begin mode = M_PROG; m_clear(); end
        end else if (d) begin
            if (mode == M_LOCKED) begin mode = M_ENTRY; m_clear(); m_push(dig); end
            else if (mode == M_PROG || mode == M_ENTRY) m_push(dig);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] e;
        e = '0;
        foreach (ent[i]) e = e | (32'(ent[i]) << (i * DW));
        check("unlock",     32'(bus.unlock),      32'(mode == M_OPEN));
        check("locked_out", 32'(bus.locked_out),  32'(mode == M_LOCKOUT));
        check("bad_code",   32'(bus.bad_code),    32'(bad_m));
        check("pw_set",     32'(bus.pw_set),      32'(pw_set_m));
        check("fail_count", 32'(bus.fail_count),  32'(fails));
        check("entry_len",  32'(bus.entry_len),   32'(ent.size()));
        check("disp",       32'(bus.disp_digits), e);
    endtask

    task automatic step(input bit c, input bit s, input bit st, input bit d, input int dig);
        bus.clear_req   = c;
        bus.submit_req  = s;
        bus.store_req   = st;
        bus.digit_valid = d;
        bus.digit_in    = DW'(dig);
        @(posedge clk);
        model_edge(c, s, st, d, dig);
        #1;
        check_model();
        bus.clear_req = 0; bus.submit_req = 0; bus.store_req = 0; bus.digit_valid = 0;
    endtask

    task automatic dig(input int d);  step(0, 0, 0, 1, d); endtask
    task automatic submit();          step(0, 1, 0, 0, 0); endtask
    task automatic store();           step(0, 0, 1, 0, 0); endtask
    task automatic idle();            step(0, 0, 0, 0, 0); endtask

    task automatic rst_assert();
        system_reset = 1'b1;
        #1;
        m_reset();
        check_model();
    endtask

    task automatic rst_release();
        @(posedge clk);
        #1;
        system_reset = 1'b0;
    endtask

    int lo_cycles;

    initial begin
        system_reset = 1'b0;
        bus.clear_req = 0; bus.submit_req = 0; bus.store_req = 0;
        bus.digit_valid = 0; bus.digit_in = '0;
        #2;
        rst_assert();
        check("reset_unlock", 32'(bus.unlock), 32'd0);
        rst_release();

        // Program 3,4,5 then enter it.
        store();
        dig(3); dig(4); dig(5);
        check("prog_disp", 32'(bus.disp_digits), 32'h0543);
        submit();
        check("pw_set_after_prog", 32'(bus.pw_set), 32'd1);
        dig(3); dig(4); dig(5); submit();
        check("unlock_after_match", 32'(bus.unlock), 32'd1);
        check("fail_zero_match", 32'(bus.fail_count), 32'd0);
        submit();
        check("relock", 32'(bus.unlock), 32'd0);

        // Short wrong code.
        dig(3); dig(4); submit();
        check("bad_pulse", 32'(bus.bad_code), 32'd1);
        check("fail_one", 32'(bus.fail_count), 32'd1);
        idle();
        check("bad_one_cycle", 32'(bus.bad_code), 32'd0);

        // Two more wrong codes -> lockout; pulses during it are ignored.
        dig(3); dig(4); submit();
        dig(9); submit();
        check("lockout_entered", 32'(bus.locked_out), 32'd1);
        lo_cycles = 1;
        for (int k = 0; k < 20 && bus.locked_out === 1'b1; k++) begin
            step(0, $urandom_range(0, 1), 0, 1, 3);
            if (bus.locked_out === 1'b1) lo_cycles++;
        end
        check("lockout_cycles", 32'(lo_cycles), 32'd10);
        check("fail_after_lockout", 32'(bus.fail_count), 32'd0);
        check("len_after_lockout", 32'(bus.entry_len), 32'd0);

        // Overflowed entry against 3-digit then 4-digit password.
        dig(3); dig(4); dig(5); dig(5); dig(5);
        check("ovf_len", 32'(bus.entry_len), 32'd4);
        submit();
        check("ovf_bad3", 32'(bus.bad_code), 32'd1);
        dig(3); dig(4); dig(5); submit();
        check("reopen", 32'(bus.unlock), 32'd1);
        store();
        dig(3); dig(4); dig(5); dig(5); submit();
        dig(3); dig(4); dig(5); dig(5); dig(5); submit();
        check("ovf_bad4", 32'(bus.bad_code), 32'd1);
        dig(3); dig(4); dig(5); dig(5); submit();
        check("match4", 32'(bus.unlock), 32'd1);
        submit();

        // clear beats submit during entry.
        dig(1); submit();
        dig(3);
        step(1, 1, 0, 0, 0);
        check("clr_sub_bad", 32'(bus.bad_code), 32'd0);
        check("clr_sub_fail", 32'(bus.fail_count), 32'd1);
        check("clr_sub_len", 32'(bus.entry_len), 32'd0);

        // Reset during lockout cycle 5.
        dig(1); submit();
        dig(1); submit();
        idle(); idle(); idle(); idle();
        check("lockout_c5", 32'(bus.locked_out), 32'd1);
        rst_assert();
        check("rst_locked_out", 32'(bus.locked_out), 32'd0);
        check("rst_pw_set", 32'(bus.pw_set), 32'd0);
        check("rst_fail", 32'(bus.fail_count), 32'd0);
        rst_release();
        store(); dig(7);
        check("store_after_rst", 32'(bus.entry_len), 32'd1);
        submit();
        check("pw_after_rst", 32'(bus.pw_set), 32'd1);

        // Random pulses, several may collide in one cycle.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_assert();
                rst_release();
            end else begin
                step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 0,
                     int'($urandom_range(3, 5)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_lock_engine.md
CODE_LOCK_ENGINE -- requirements
Module: code_lock_engine

Interface
REQ-001 Parameter DIGIT_W, default 4: bits per code digit.
REQ-002 Parameter MAX_LEN, default 8: maximum stored/entered digits.
REQ-003 Parameter MAX_FAILS, default 3: consecutive mismatches that trigger lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 50_000_000: lockout duration in clk cycles (1 s at 50 MHz).
REQ-005 clk  input  1  single clock for all state.
REQ-006 system_reset  input  1  asynchronous, active-high reset.
REQ-007 digit_in  input  DIGIT_W  digit value, sampled when digit_valid=1.
REQ-008 digit_valid  input  1  single-cycle pulse; debounced upstream.
REQ-009 store_req  input  1  single-cycle pulse; begin programming.
REQ-010 submit_req  input  1  single-cycle pulse; finish programming, compare, or relock.
REQ-011 clear_req  input  1  single-cycle pulse; abort current sequence.
REQ-012 unlock  output  1  high while in OPEN.
REQ-013 locked_out  output  1  high while in LOCKOUT.
REQ-014 bad_code  output  1  one-cycle pulse on each mismatch.
REQ-015 pw_set  output  1  a password is stored.
REQ-016 fail_count  output  clog2(MAX_FAILS+1)  consecutive mismatches.
REQ-017 entry_len  output  clog2(MAX_LEN+1)  digits captured in current sequence, saturating at MAX_LEN.
REQ-018 disp_digits  output  MAX_LEN*DIGIT_W  captured digits, digit 0 in LSBs, for hex display.

Function
REQ-019 States SHALL be LOCKED, PROG, ENTRY, OPEN and LOCKOUT.
REQ-020 Simultaneous request priority SHALL be clear_req > submit_req > store_req > digit_valid; lower-priority requests in the same cycle are dropped.
REQ-021 In LOCKED: digit_valid -> ENTRY with the digit captured at index 0; store_req -> PROG only when pw_set=0, otherwise ignored.
REQ-022 In PROG/ENTRY, each digit_valid SHALL write digit_in to index entry_len and increment entry_len; digits beyond MAX_LEN are discarded and set an internal overflow flag.
REQ-023 In PROG, submit_req with entry_len>=1 SHALL store the digits and length, set pw_set=1, and go to LOCKED; with entry_len=0 it returns to LOCKED with the old password kept.
REQ-024 In ENTRY, submit_req SHALL match iff pw_set=1, overflow=0, entry_len equals stored length, and all stored digits are equal.
REQ-025 On match: OPEN, fail_count=0, unlock high from the first cycle after the clk edge sampling submit_req.
REQ-026 On mismatch: bad_code pulses that next cycle and fail_count increments; reaching MAX_FAILS -> LOCKOUT, otherwise -> LOCKED.
REQ-027 clear_req in PROG/ENTRY SHALL return to LOCKED without changing the stored password or fail_count.
REQ-028 In OPEN: submit_req -> LOCKED; store_req -> PROG (reprogramming allowed); digit_valid ignored.
REQ-029 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles and ignore all requests; on exit -> LOCKED with fail_count=0.
REQ-030 entry_len, overflow and disp_digits SHALL clear on every transition into LOCKED, PROG or ENTRY-from-LOCKED (before capturing the first digit).

Reset
REQ-031 On system_reset, asynchronously: state=LOCKED; stored digits, stored length and pw_set=0; unlock, locked_out, bad_code, fail_count, entry_len and disp_digits all 0; lockout timer cleared.
REQ-032 Reset asserted mid-sequence or mid-lockout SHALL abort it with no residual state.

Structure
REQ-033 State encoding and parameter defaults SHALL live in shared package lock_pkg.
REQ-034 The lockout counter SHALL be sub-module lockout_timer: inputs start and count; output done pulse after LOCKOUT_CYCLES cycles.

Verification (DIGIT_W=4, MAX_LEN=4, MAX_FAILS=3, LOCKOUT_CYCLES=10)
REQ-035 Program store, 3, 4, 5, submit; then enter 3, 4, 5, submit -> pw_set=1, unlock=1 on the cycle after submit, fail_count=0.
REQ-036 Enter 3, 4, submit -> bad_code pulse for one cycle, fail_count=1, unlock=0, state LOCKED.
REQ-037 Three wrong codes -> locked_out=1 for exactly 10 cycles, digit and submit pulses ignored, then fail_count=0.
REQ-038 Enter 3, 4, 5, 5, 5 (overflow) then submit -> mismatch with entry_len=4; the same digits against a 4-digit password 3, 4, 5, 5 also mismatch.
REQ-039 clear_req and submit_req in the same cycle during ENTRY -> LOCKED, no bad_code, fail_count unchanged.
REQ-040 system_reset during LOCKOUT cycle 5 -> all outputs 0 immediately, pw_set=0, store_req then accepted.
